// File: rtl/send_data_pkg.sv
// Shared constants and state encodings for the result transmit path.
// Imported by send_data and uart_txd.
package send_data_pkg;

   localparam int RESULT_BYTES     = 4;
   localparam int DEF_CLKS_PER_BIT = 868;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      WAIT_TX,
      DONE
   } send_state_t;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/uart_txd.sv
// 8N1 UART byte transmitter with bit timing and bit index.
// txd_done stays high from end of stop bit until the next start.
module uart_txd
   import send_data_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       txd_start,
   input  logic [7:0] txd_data,
   output logic       txd_busy,
   output logic       txd_done,
   output logic       txd_data_out
);

   localparam int CW = cnt_width(CLKS_PER_BIT);

   tx_state_t      st;
   tx_state_t      nxt;
   logic [CW-1:0]  clk_cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     data_q;
   logic           tick;

   assign tick     = (clk_cnt == CW'(CLKS_PER_BIT - 1));
   assign txd_busy = (st != TX_IDLE);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) st <= TX_IDLE;
      else      st <= nxt;
   end

   always_comb begin
      nxt = st;
      unique case (st)
         TX_IDLE:  if (txd_start) nxt = TX_START;
         TX_START: if (tick) nxt = TX_DATA;
         TX_DATA:  if (tick && bit_idx == 3'd7) nxt = TX_STOP;
         TX_STOP:  if (tick) nxt = TX_IDLE;
         default:  nxt = TX_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         clk_cnt  <= '0;
         bit_idx  <= '0;
         data_q   <= '0;
         txd_done <= 1'b0;
      end else begin
         if (st == TX_IDLE || tick) clk_cnt <= '0;
         else                       clk_cnt <= clk_cnt + CW'(1);
         if (st == TX_IDLE && txd_start) begin
            data_q   <= txd_data;
            txd_done <= 1'b0;
         end
         // LSB leaves first; bit_idx wraps back to 0 after bit 7
         if (st == TX_DATA && tick) begin
            data_q  <= {1'b0, data_q[7:1]};
            bit_idx <= bit_idx + 3'd1;
         end
         if (st == TX_STOP && tick) txd_done <= 1'b1;
      end
   end

   always_comb begin
      txd_data_out = 1'b1;
      unique case (st)
         TX_START: txd_data_out = 1'b0;
         TX_DATA:  txd_data_out = data_q[0];
         default:  txd_data_out = 1'b1;
      endcase
   end

endmodule

// File: rtl/send_data.sv
// Captures a result word and sends it MSB byte first over UART,
// pulsing send_done after the last stop bit.
module send_data
   import send_data_pkg::*;
#(
   parameter int NUM_BYTES    = RESULT_BYTES,
   parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   send_start,
   input  logic [NUM_BYTES*8-1:0] result_in,
   output logic                   txd_data_out_top,
   output logic                   send_busy,
   output logic                   send_done
);

   localparam int W  = NUM_BYTES * 8;
   localparam int CW = cnt_width(NUM_BYTES);

   send_state_t    state;
   send_state_t    nxt;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   shreg;
   logic           txd_start;
   logic           txd_busy;
   logic           txd_done;
   logic           done_q;
   logic           done_rise;
   logic           last;

   // txd_done is a level; only its rising edge ends a byte
   assign done_rise = txd_done & ~done_q & ~txd_busy;
   assign last      = (cnt == CW'(NUM_BYTES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nxt;
   end

   always_comb begin
      nxt       = state;
      send_busy = 1'b1;
      send_done = 1'b0;
      unique case (state)
         IDLE: begin
            send_busy = 1'b0;
            if (send_start) nxt = LOAD;
         end
         LOAD:    nxt = WAIT_TX;
         WAIT_TX: if (done_rise) nxt = last ? DONE : LOAD;
         DONE: begin
            send_done = 1'b1;
            nxt       = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         shreg     <= '0;
         txd_start <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q    <= txd_done;
         txd_start <= (state == LOAD);
         if (state == IDLE && send_start) begin
            shreg <= result_in;
            cnt   <= '0;
         end
         if (state == WAIT_TX && done_rise && !last) begin
            shreg <= shreg << 8;
            cnt   <= cnt + CW'(1);
         end
      end
   end

   uart_txd #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_txd (
      .clk         (clk),
      .rst         (rst),
      .txd_start   (txd_start),
      .txd_data    (shreg[W-1 -: 8]),
      .txd_busy    (txd_busy),
      .txd_done    (txd_done),
      .txd_data_out(txd_data_out_top)
   );

endmodule

// File: tb/tb_send_data.sv
// Directed and random checks of send_data against a byte-level
// reference model decoded by a mid-bit UART monitor.
module tb_send_data;

   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   logic        clk;
   logic        rst;
   logic        ss0;
   logic [31:0] ri0;
   logic        line0;
   logic        busy0;
   logic        done0;
   logic        ss1;
   logic [7:0]  ri1;
   logic        line1;
   logic        busy1;
   logic        done1;

   int vectors     = 0;
   int miscompares = 0;
   int fe0 = 0;
   int fe1 = 0;
   int dc0 = 0;
   int dc1 = 0;
   logic [7:0] q0[$];
   logic [7:0] q1[$];

   send_data #(.NUM_BYTES(4), .CLKS_PER_BIT(CPB)) dut0 (
      .clk             (clk),
      .rst             (rst),
      .send_start      (ss0),
      .result_in       (ri0),
      .txd_data_out_top(line0),
      .send_busy       (busy0),
      .send_done       (done0)
   );

   send_data #(.NUM_BYTES(1), .CLKS_PER_BIT(CPB)) dut1 (
      .clk             (clk),
      .rst             (rst),
      .send_start      (ss1),
      .result_in       (ri1),
      .txd_data_out_top(line1),
      .send_busy       (busy1),
      .send_done       (done1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (done0 === 1'b1) dc0++;
      if (done1 === 1'b1) dc1++;
   end

   function automatic logic lineof(input int w);
      return (w == 0) ? line0 : line1;
   endfunction

   function automatic logic busyof(input int w);
      return (w == 0) ? busy0 : busy1;
   endfunction

   function automatic logic doneof(input int w);
      return (w == 0) ? done0 : done1;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_range(input string tag, input int v,
                              input int lo, input int hi);
      vectors++;
      assert (v >= lo && v <= hi) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, v, lo, hi);
      end
   endtask

   task automatic ferr(input int w);
      if (w == 0) fe0++;
      else        fe1++;
   endtask

   // Entered half a cycle into a start bit; samples every bit mid-way
   task automatic mon_frame(input int w, output bit ok,
                            output logic [7:0] b);
      ok = 1'b0;
      b  = '0;
      @(negedge clk);
      if (!rst) return;
      if (lineof(w) !== 1'b0) begin
         ferr(w);
         return;
      end
      for (int i = 0; i < 8; i++) begin
         repeat (CPB) @(negedge clk);
         if (!rst) return;
         b[i] = lineof(w);
      end
      repeat (CPB) @(negedge clk);
      if (!rst) return;
      if (lineof(w) !== 1'b1) ferr(w);
      else                    ok = 1'b1;
   endtask

   initial begin : mon0
      bit         ok;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && line0 === 1'b0) begin
            mon_frame(0, ok, b);
            if (ok) q0.push_back(b);
         end
      end
   end

   initial begin : mon1
      bit         ok;
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rst === 1'b1 && line1 === 1'b0) begin
            mon_frame(1, ok, b);
            if (ok) q1.push_back(b);
         end
      end
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic launch(input int w, input logic [31:0] word);
      @(negedge clk);
      if (w == 0) begin
         ri0 = word;
         ss0 = 1'b1;
      end else begin
         ri1 = word[7:0];
         ss1 = 1'b1;
      end
      @(negedge clk);
      ss0 = 1'b0;
      ss1 = 1'b0;
      ri0 = $urandom;
      ri1 = 8'($urandom);
   endtask

   // Returns on the negedge where send_done is seen
   task automatic run(input int w, input logic [31:0] word,
                      input int inj_at, input bit poke,
                      output int busy_cyc);
      bit seen;
      launch(w, word);
      busy_cyc = 0;
      seen     = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         if (n > 0) @(negedge clk);
         if (busyof(w) === 1'b1) busy_cyc++;
         if (n == inj_at) begin
            ri0 = '1;
            ri1 = '1;
            if (w == 0) ss0 = 1'b1;
            else        ss1 = 1'b1;
         end else begin
            ss0 = 1'b0;
            ss1 = 1'b0;
         end
         if (doneof(w) === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      ss0 = 1'b0;
      ss1 = 1'b0;
      check("done_seen", 64'(seen), 64'd1);
      if (poke) begin
         ri0 = $urandom;
         if (w == 0) ss0 = 1'b1;
         else        ss1 = 1'b1;
         @(negedge clk);
         ss0 = 1'b0;
         ss1 = 1'b0;
         check("busy_after_done_poke", 64'(busyof(w)), 64'd0);
      end
   endtask

   task automatic expect_word(input int w, input logic [31:0] word,
                              input int nb, input string tag);
      logic [7:0] exp;
      logic [7:0] got;
      for (int i = 0; i < nb; i++) begin
         exp = 8'(word >> (8 * (nb - 1 - i)));
         got = 'x;
         if (w == 0 && q0.size() > 0) got = q0.pop_front();
         if (w == 1 && q1.size() > 0) got = q1.pop_front();
         check($sformatf("%s_byte%0d", tag, i), 64'(got), 64'(exp));
      end
   endtask

   task automatic send_check(input logic [31:0] word, input string tag);
      int b;
      int d;
      d = dc0;
      run(0, word, -1, 1'b0, b);
      check_range({tag, "_busy_len"}, b, 4 * FRAME + 1, 4 * (FRAME + 3) + 1);
      @(negedge clk);
      check({tag, "_busy_drop"}, 64'(busy0), 64'd0);
      check({tag, "_done_cnt"}, 64'(dc0 - d), 64'd1);
      check({tag, "_qsize"}, 64'(q0.size()), 64'd4);
      expect_word(0, word, 4, tag);
   endtask

   initial begin : stim
      int          b;
      int          d;
      int          bad;
      logic [31:0] w;

      rst = 1'b0;
      ss0 = 1'b0;
      ss1 = 1'b0;
      ri0 = '0;
      ri1 = '0;
      repeat (5) @(negedge clk);
      check("rst_line0", 64'(line0), 64'd1);
      check("rst_busy0", 64'(busy0), 64'd0);
      check("rst_done0", 64'(done0), 64'd0);
      check("rst_line1", 64'(line1), 64'd1);
      check("rst_busy1", 64'(busy1), 64'd0);

      rst = 1'b1;
      bad = 0;
      repeat (100) begin
         @(negedge clk);
         if (line0 !== 1'b1 || line1 !== 1'b1 || busy0 !== 1'b0) bad++;
      end
      check("idle_quiet", 64'(bad), 64'd0);

      send_check(32'hDEADBEEF, "single");

      d = dc0;
      run(0, 32'h01234567, -1, 1'b0, b);
      run(0, 32'h89ABCDEF, -1, 1'b0, b);
      @(negedge clk);
      check("b2b_done_cnt", 64'(dc0 - d), 64'd2);
      check("b2b_qsize", 64'(q0.size()), 64'd8);
      expect_word(0, 32'h01234567, 4, "b2b_a");
      expect_word(0, 32'h89ABCDEF, 4, "b2b_b");

      d = dc0;
      run(0, 32'h00000000, 2 * (FRAME + 3) + 10, 1'b0, b);
      @(negedge clk);
      check("ign_done_cnt", 64'(dc0 - d), 64'd1);
      check("ign_qsize", 64'(q0.size()), 64'd4);
      expect_word(0, 32'h00000000, 4, "ign");
      repeat (80) @(negedge clk);
      check("ign_no_resend", 64'(q0.size()), 64'd0);
      check("ign_idle", 64'(busy0), 64'd0);

      w = $urandom;
      d = dc0;
      run(0, w, -1, 1'b1, b);
      repeat (60) @(negedge clk);
      check("poke_done_cnt", 64'(dc0 - d), 64'd1);
      check("poke_qsize", 64'(q0.size()), 64'd4);
      expect_word(0, w, 4, "poke");

      for (int k = 0; k < 3; k++) begin
         send_check($urandom, $sformatf("rand%0d", k));
      end

      d = dc0;
      launch(0, 32'h12005678);
      repeat (61) @(negedge clk);
      @(posedge clk);
      #2;
      check("pre_reset_line", 64'(line0), 64'd0);
      rst = 1'b0;
      #1;
      check("reset_line_now", 64'(line0), 64'd1);
      repeat (5) @(negedge clk);
      check("reset_busy", 64'(busy0), 64'd0);
      check("reset_no_done", 64'(dc0 - d), 64'd0);
      check("reset_partial_q", 64'(q0.size()), 64'd1);
      q0.delete();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      send_check(32'hA5A5A5A5, "post_rst");

      d = dc1;
      run(1, 32'h00000080, -1, 1'b0, b);
      check_range("nb1_busy_len", b, FRAME + 1, FRAME + 4);
      @(negedge clk);
      check("nb1_done_cnt", 64'(dc1 - d), 64'd1);
      check("nb1_qsize", 64'(q1.size()), 64'd1);
      expect_word(1, 32'h00000080, 1, "nb1");

      w = 32'($urandom_range(0, 255));
      d = dc1;
      run(1, w, -1, 1'b0, b);
      @(negedge clk);
      check("nb1r_done_cnt", 64'(dc1 - d), 64'd1);
      check("nb1r_qsize", 64'(q1.size()), 64'd1);
      expect_word(1, w, 1, "nb1r");

      check("framing0", 64'(fe0), 64'd0);
      check("framing1", 64'(fe1), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
